// File: rtl/ram_scan_pkg.sv
// ram_scan_pkg: shared state encoding and default widths for the RAM scan reader.
package ram_scan_pkg;
  typedef enum logic {S_WAIT, S_SHOW} scan_state_t;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 4;
endpackage

// File: rtl/ram_scan_reader_tick_gen.sv
// tick_gen: prescaler emitting a one-cycle tick every TICKS_PER_STEP enabled cycles.
module tick_gen #(
  parameter int TICKS_PER_STEP = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int CW = $clog2(TICKS_PER_STEP);
  logic [CW-1:0] cnt;
  assign tick = enable && cnt == CW'(TICKS_PER_STEP - 1);
  // Held at zero while disabled so re-enable restarts a full period.
  always_ff @(posedge clk)
    cnt <= (reset || !enable || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/ram_scan_reader.sv
// ram_scan_reader: walks a synchronous RAM read port and latches address/data for display.
// Optional single-step input enabled by defining RAM_SCAN_STEP_EN.
module ram_scan_reader
  import ram_scan_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TICKS_PER_STEP = 50_000_000,
  parameter int RD_LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] disp_addr,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic                  disp_valid
`ifdef RAM_SCAN_STEP_EN
  ,
  input  logic                  step
`endif
);
  localparam int WCW = $clog2(RD_LATENCY + 2);
  scan_state_t state, state_nx;
  logic [WCW-1:0] wait_cnt;
  logic [ADDR_WIDTH-1:0] pend_addr, adv_addr;
  logic load_pend, tick, step_ev, done, adv;
  tick_gen #(.TICKS_PER_STEP(TICKS_PER_STEP)) u_tick (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .tick(tick)
  );
`ifdef RAM_SCAN_STEP_EN
  assign step_ev = step && !enable;
`else
  assign step_ev = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= reset ? S_WAIT : state_nx;
  always_comb
    state_nx = done ? S_SHOW : adv ? S_WAIT : state;
  // Capture lands RD_LATENCY+1 edges after rd_addr moved.
  always_comb begin
    done     = state == S_WAIT && wait_cnt == WCW'(RD_LATENCY);
    adv      = state == S_SHOW && (load_pend || load || tick || step_ev);
    adv_addr = load_pend ? pend_addr : load ? load_addr : rd_addr + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= '0;
      rd_addr    <= '0;
      disp_addr  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      load_pend  <= 1'b0;
      pend_addr  <= '0;
    end else begin
      wait_cnt  <= adv ? '0 : (state == S_WAIT && !done) ? wait_cnt + 1'b1 : wait_cnt;
      load_pend <= state == S_WAIT && (load_pend || load);
      if (state == S_WAIT && load) pend_addr <= load_addr;
      if (adv) rd_addr <= adv_addr;
      if (done) begin
        disp_addr  <= rd_addr;
        disp_data  <= rd_data;
        disp_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ram_scan_reader.sv
// tb_ram_scan_reader: randomized and directed checks against a timeline model of the scan reader.
module tb_ram_scan_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, enable, load;
  logic [4:0] load_addr, rd_addr, disp_addr, ram_a;
  logic [3:0] rd_data, disp_data;
  logic disp_valid;
`ifdef RAM_SCAN_STEP_EN
  logic step;
`endif
  int n_cmp = 0, n_bad = 0;
  function automatic logic [3:0] mem_f(logic [4:0] a);
    return a[3:0] ^ 4'h5;
  endfunction
  always_ff @(posedge clk) begin
    ram_a   <= rd_addr;
    rd_data <= mem_f(ram_a);
  end
  ram_scan_reader #(.ADDR_WIDTH(5), .DATA_WIDTH(4), .TICKS_PER_STEP(8), .RD_LATENCY(2)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .load(load),
    .load_addr(load_addr),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .disp_addr(disp_addr),
    .disp_data(disp_data),
    .disp_valid(disp_valid)
`ifdef RAM_SCAN_STEP_EN
    ,
    .step(step)
`endif
  );
  // Timeline model: edge index, scheduled capture edge (-1 = idle), consecutive enabled cycles.
  int n = 0, cap_at = -1, run = 0;
  logic [4:0] m_rd, m_pa, m_da;
  logic [3:0] m_dd;
  logic m_dv, m_pend;
  task automatic check(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask
  task automatic model_edge();
    logic tk, st, adv;
    n++;
    if (reset) begin
      m_rd = 0; cap_at = n + 3; m_pend = 0; m_pa = 0;
      m_da = 0; m_dd = 0; m_dv = 0; run = 0;
      return;
    end
    run = enable ? run + 1 : 0;
    tk = enable && run % 8 == 0;
    st = 1'b0;
`ifdef RAM_SCAN_STEP_EN
    st = step && !enable;
`endif
    if (cap_at >= 0) begin
      if (n == cap_at) begin
        m_da = m_rd; m_dd = mem_f(m_rd); m_dv = 1; cap_at = -1;
      end
      if (load) begin
        m_pend = 1; m_pa = load_addr;
      end
    end else begin
      adv = 1;
      if (m_pend) begin
        m_rd = m_pa; m_pend = 0;
      end else if (load) m_rd = load_addr;
      else if (tk || st) m_rd = m_rd + 5'd1;
      else adv = 0;
      if (adv) cap_at = n + 3;
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("rd_addr", rd_addr, m_rd);
    check("disp_addr", disp_addr, m_da);
    check("disp_data", disp_data, m_dd);
    check("disp_valid", disp_valid, m_dv);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (cap_at < 0) return;
      cyc();
    end
    check("idle_timeout", 0, 1);
  endtask
  initial begin
    logic [4:0] a, prev;
    int k;
    logic wrap;
    reset = 1; enable = 1; load = 0; load_addr = 0;
`ifdef RAM_SCAN_STEP_EN
    step = 0;
`endif
    cyc();
    reset = 0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      if (i < 3) check("rst_lat_valid", disp_valid, 0);
      else begin
        check("rst_cap_valid", disp_valid, 1);
        check("rst_cap_addr", disp_addr, 0);
        check("rst_cap_data", disp_data, 4'h5);
      end
    end
    wrap = 0;
    prev = disp_addr;
    repeat (297) begin
      cyc();
      if (prev == 5'h1F && disp_addr == 5'h00 && disp_data == 4'h5) wrap = 1;
      prev = disp_addr;
    end
    check("wrap_seen", wrap, 1);
    enable = 0;
    wait_idle();
    a = disp_addr;
    repeat (20) cyc();
    check("frozen_addr", disp_addr, a);
    enable = 1;
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      cyc();
      if (disp_addr != a) k = i;
    end
    check("reenable_lat", k, 11);
    enable = 0;
    wait_idle();
    load = 1; load_addr = 5'h15;
    cyc();
    load = 0;
    repeat (3) cyc();
    check("load_addr", disp_addr, 5'h15);
    check("load_data", disp_data, 4'h0);
    load = 1; load_addr = 5'h03;
    cyc();
    load_addr = 5'h0A;
    cyc();
    load = 0;
    repeat (5) cyc();
    check("pend_first", disp_addr, 5'h03);
    cyc();
    check("pend_applied", disp_addr, 5'h0A);
    wait_idle();
    load = 1; load_addr = 5'h1C;
    cyc();
    load = 0;
    reset = 1;
    cyc();
    check("midrst_addr", disp_addr, 0);
    check("midrst_valid", disp_valid, 0);
    check("midrst_rd", rd_addr, 0);
    reset = 0;
    repeat (3) cyc();
    check("midrst_recap", disp_valid, 1);
    check("midrst_recap_addr", disp_addr, 0);
`ifdef RAM_SCAN_STEP_EN
    wait_idle();
    a = disp_addr;
    step = 1;
    cyc();
    step = 0;
    repeat (3) cyc();
    check("step_one", disp_addr, a + 5'd1);
    step = 1;
    cyc();
    cyc();
    step = 0;
    repeat (12) cyc();
    check("step_in_wait", disp_addr, a + 5'd2);
`endif
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      load = $urandom_range(0, 15) == 0;
      load_addr = 5'($urandom);
      reset = $urandom_range(0, 299) == 0;
`ifdef RAM_SCAN_STEP_EN
      step = $urandom_range(0, 5) == 0;
`endif
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
